life_engine_param: RTL and testbench

- Parametrised Conway/Life-like cellular automaton engine. Supersedes the fixed 8x8, vsync-clocked board logic.
- Runs entirely on the system pixel clock. A generation is triggered by a one-cycle frame tick or a manual step pulse.
- Double-buffered: the display read port always sees a complete, stable generation.
- Adds over the fixed version: configurable board size, selectable toroidal wrap, programmable birth/survive rule, single-cell write, generation and population counters.

---
 rtl/life_engine_param.sv | 168 ++++++++++++++++
 tb/tb_life_engine_param.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_engine_param.sv
// Parametrised Life-like cellular automaton engine with a double-buffered board.
// Each clock in EVAL computes one cell of the next generation from a frozen snapshot.
module life_engine_param #(
    parameter int unsigned W_BITS       = 3,
    parameter int unsigned H_BITS       = 3,
    parameter logic [(2**(W_BITS+H_BITS))-1:0] SEED = '0,
    parameter logic [8:0]  BIRTH_MASK   = 9'b000001000,
    parameter logic [8:0]  SURVIVE_MASK = 9'b000001100,
    parameter int unsigned GEN_BITS     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_tick,
    input  logic                       run,
    input  logic                       step,
    input  logic                       wrap,
    input  logic                       seed_load,
    input  logic                       cell_wr,
    input  logic [W_BITS-1:0]          cell_wr_x,
    input  logic [H_BITS-1:0]          cell_wr_y,
    input  logic                       cell_wr_val,
    input  logic [W_BITS-1:0]          rd_x,
    input  logic [H_BITS-1:0]          rd_y,
    output logic                       rd_cell,
    output logic                       busy,
    output logic                       gen_done,
    output logic [GEN_BITS-1:0]        gen_count,
    output logic [W_BITS+H_BITS:0]     pop_count
);

    localparam int unsigned BOARD_W = 2**W_BITS;
    localparam int unsigned BOARD_H = 2**H_BITS;
    localparam int unsigned N       = BOARD_W * BOARD_H;
    localparam int unsigned IDX     = W_BITS + H_BITS;

    typedef enum logic [1:0] {StIdle, StSnap, StEval, StDone} state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      cur_q, cur_d;
    logic [N-1:0]      snap_q, snap_d;
    logic              wrap_q, wrap_d;
    logic [IDX-1:0]    idx_q, idx_d;
    logic [IDX:0]      acc_q, acc_d;
    logic [GEN_BITS-1:0] gen_q, gen_d;
    logic [IDX:0]      pop_q, pop_d;

    logic              trigger;
    logic [IDX-1:0]    wr_addr;
    logic [IDX-1:0]    rd_addr;

    logic [W_BITS-1:0] cx, xm, xp;
    logic [H_BITS-1:0] cy, ym, yp;
    logic              xm_ok, xp_ok, ym_ok, yp_ok;
    logic [3:0]        nbr_cnt;
    logic [15:0]       birth_ext, survive_ext;
    logic              new_cell;

    function automatic logic [3:0] nb(input logic [N-1:0] b, input logic [H_BITS-1:0] y,
                                      input logic [W_BITS-1:0] x, input logic ok);
        return {3'b000, b[{y, x}] & ok};
    endfunction

    assign trigger = (frame_tick & run) | step;
    assign wr_addr = {cell_wr_y, cell_wr_x};
    assign rd_addr = {rd_y, rd_x};

    // Neighbour coordinates wrap naturally in their field widths; the _ok flags
    // mask the off-board ones when the torus is disabled.
    assign {cy, cx} = idx_q;
    assign xm    = cx - W_BITS'(1);
    assign xp    = cx + W_BITS'(1);
    assign ym    = cy - H_BITS'(1);
    assign yp    = cy + H_BITS'(1);
    assign xm_ok = wrap_q | (cx != '0);
    assign xp_ok = wrap_q | (cx != '1);
    assign ym_ok = wrap_q | (cy != '0);
    assign yp_ok = wrap_q | (cy != '1);

    always_comb begin
        nbr_cnt = nb(snap_q, ym, xm, ym_ok & xm_ok)
                + nb(snap_q, ym, cx, ym_ok)
                + nb(snap_q, ym, xp, ym_ok & xp_ok)
                + nb(snap_q, cy, xm, xm_ok)
                + nb(snap_q, cy, xp, xp_ok)
                + nb(snap_q, yp, xm, yp_ok & xm_ok)
                + nb(snap_q, yp, cx, yp_ok)
                + nb(snap_q, yp, xp, yp_ok & xp_ok);
    end

    assign birth_ext   = {7'b0000000, BIRTH_MASK};
    assign survive_ext = {7'b0000000, SURVIVE_MASK};
    assign new_cell    = snap_q[idx_q] ? survive_ext[nbr_cnt] : birth_ext[nbr_cnt];

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        snap_d  = snap_q;
        wrap_d  = wrap_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        gen_d   = gen_q;
        pop_d   = pop_q;
        unique case (state_q)
            StIdle: begin
                if (seed_load) begin
                    cur_d = SEED;
                end else if (cell_wr) begin
                    cur_d[wr_addr] = cell_wr_val;
                end else if (trigger) begin
                    // Freeze the board on entry so the display sees it during SNAP too.
                    wrap_d  = wrap;
                    snap_d  = cur_q;
                    state_d = StSnap;
                end
            end
            StSnap: begin
                idx_d   = '0;
                acc_d   = '0;
                state_d = StEval;
            end
            StEval: begin
                cur_d[idx_q] = new_cell;
                acc_d        = acc_q + (IDX+1)'(new_cell);
                idx_d        = idx_q + IDX'(1);
                if (idx_q == '1) begin
                    state_d = StDone;
                    gen_d   = gen_q + GEN_BITS'(1);
                    pop_d   = acc_d;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cur_q   <= SEED;
            snap_q  <= '0;
            wrap_q  <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            gen_q   <= '0;
            pop_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            snap_q  <= snap_d;
            wrap_q  <= wrap_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            gen_q   <= gen_d;
            pop_q   <= pop_d;
        end
    end

    assign busy      = (state_q == StSnap) || (state_q == StEval);
    assign gen_done  = (state_q == StDone);
    assign gen_count = gen_q;
    assign pop_count = pop_q;
    assign rd_cell   = busy ? snap_q[rd_addr] : cur_q[rd_addr];

endmodule

// File: tb/tb_life_engine_param.sv
// Bench for life_engine_param: whole-board generation model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_life_engine_param;

    localparam int unsigned BW = 8;
    localparam int unsigned BH = 8;
    localparam int unsigned N  = 64;
    localparam logic [63:0] SEED_PAT = 64'h0000_0000_0007_0402;  // glider
    localparam logic [8:0]  BM = 9'b000001000;
    localparam logic [8:0]  SM = 9'b000001100;

    logic clk = 1'b0, rst_n = 1'b0;
    logic frame_tick = 1'b0, run = 1'b0, step = 1'b0, wrap = 1'b0, seed_load = 1'b0;
    logic cell_wr = 1'b0, cell_wr_val = 1'b0;
    logic [2:0] cell_wr_x = '0, cell_wr_y = '0;
    logic [2:0] rd_x, rd_y;
    logic [5:0] sweep_addr = '0, man_addr = '0;
    logic use_man = 1'b0;
    logic rd_cell, busy, gen_done, rd_cell2, busy2, gen_done2;
    logic [15:0] gen_count, gen_count2;
    logic [6:0] pop_count, pop_count2;

    int checks = 0;
    int failures = 0;

    assign {rd_y, rd_x} = use_man ? man_addr : sweep_addr;

    always #5 clk = ~clk;

    life_engine_param #(.W_BITS(3), .H_BITS(3), .SEED(SEED_PAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .step(step),
        .wrap(wrap), .seed_load(seed_load), .cell_wr(cell_wr), .cell_wr_x(cell_wr_x),
        .cell_wr_y(cell_wr_y), .cell_wr_val(cell_wr_val), .rd_x(rd_x), .rd_y(rd_y),
        .rd_cell(rd_cell), .busy(busy), .gen_done(gen_done), .gen_count(gen_count),
        .pop_count(pop_count)
    );

    // B1/S rule instance, fed identically; SEED left at zero.
    life_engine_param #(.W_BITS(3), .H_BITS(3), .BIRTH_MASK(9'b000000010),
                        .SURVIVE_MASK(9'b000000000)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .step(step),
        .wrap(wrap), .seed_load(seed_load), .cell_wr(cell_wr), .cell_wr_x(cell_wr_x),
        .cell_wr_y(cell_wr_y), .cell_wr_val(cell_wr_val), .rd_x(rd_x), .rd_y(rd_y),
        .rd_cell(rd_cell2), .busy(busy2), .gen_done(gen_done2), .gen_count(gen_count2),
        .pop_count(pop_count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_cur[N];
    bit m_next[N];
    int m_phase = 0;   // 0 idle, 1 snap, 2..N+1 eval, N+2 done
    int m_gen = 0;
    int m_pop = 0;
    int m_next_pop = 0;

    function automatic void compute_next(input bit w);
        m_next_pop = 0;
        for (int y = 0; y < BH; y++) begin
            for (int x = 0; x < BW; x++) begin
                int n;
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        int nx, ny;
                        nx = x + dx;
                        ny = y + dy;
                        if (dx == 0 && dy == 0) continue;
                        if (w) begin
                            nx = (nx + BW) % BW;
                            ny = (ny + BH) % BH;
                        end else if (nx < 0 || nx >= BW || ny < 0 || ny >= BH) begin
                            continue;
                        end
                        n += int'(m_cur[ny*BW + nx]);
                    end
                end
                m_next[y*BW + x] = m_cur[y*BW + x] ? SM[n] : BM[n];
                m_next_pop += int'(m_next[y*BW + x]);
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) m_cur[k] = SEED_PAT[k];
            m_phase = 0;
            m_gen   = 0;
            m_pop   = 0;
        end else if (m_phase == 0) begin
            if (seed_load) begin
                for (int k = 0; k < N; k++) m_cur[k] = SEED_PAT[k];
            end else if (cell_wr) begin
                m_cur[int'(cell_wr_y)*BW + int'(cell_wr_x)] = cell_wr_val;
            end else if ((frame_tick && run) || step) begin
                compute_next(wrap);
                m_phase = 1;
            end
        end else if (m_phase == N + 1) begin
            m_cur   = m_next;
            m_gen   = m_gen + 1;
            m_pop   = m_next_pop;
            m_phase = N + 2;
        end else if (m_phase == N + 2) begin
            m_phase = 0;
        end else begin
            m_phase = m_phase + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        sweep_addr = sweep_addr + 6'd1;
    end

    always @(negedge clk) begin
        check("busy", {31'b0, busy}, {31'b0, (m_phase >= 1 && m_phase <= N + 1)});
        check("gen_done", {31'b0, gen_done}, {31'b0, (m_phase == N + 2)});
        check("rd_cell", {31'b0, rd_cell}, {31'b0, m_cur[{rd_y, rd_x}]});
        check("busy2", {31'b0, busy2}, {31'b0, busy});
        check("gen_done2", {31'b0, gen_done2}, {31'b0, gen_done});
        if (m_phase != N + 2) begin
            check("gen_count", {16'b0, gen_count}, m_gen & 32'h0000_ffff);
            check("pop_count", {25'b0, pop_count}, m_pop);
            check("gen_count2", {16'b0, gen_count2}, {16'b0, gen_count});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_write(input int x, input int y, input logic v);
        cell_wr_x   = 3'(x);
        cell_wr_y   = 3'(y);
        cell_wr_val = v;
        cell_wr     = 1'b1;
        tick();
        cell_wr     = 1'b0;
    endtask

    task automatic do_step(input logic w);
        wrap = w;
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic clear_board();
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++) do_write(x, y, 1'b0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (gen_done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check("gen_done seen", {31'b0, gen_done}, 32'd1);
        tick();
    endtask

    task automatic expect_cell(input string name, input int x, input int y, input bit second,
                               input logic exp);
        logic v;
        man_addr = 6'(y*BW + x);
        use_man  = 1'b1;
        #1;
        v = second ? rd_cell2 : rd_cell;
        use_man = 1'b0;
        check(name, {31'b0, v}, {31'b0, exp});
        tick();
    endtask

    task automatic count_seed_mismatch(output int mism);
        logic v;
        mism = 0;
        for (int k = 0; k < N; k++) begin
            man_addr = 6'(k);
            use_man  = 1'b1;
            #1;
            v = rd_cell;
            use_man = 1'b0;
            if (v !== SEED_PAT[k]) mism++;
            tick();
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int cyc, busy_cycles, n, mism;
        logic v;

        repeat (3) @(posedge clk);
        #2;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset gen_done", {31'b0, gen_done}, 32'd0);
        check("reset gen_count", {16'b0, gen_count}, 32'd0);
        check("reset pop_count", {25'b0, pop_count}, 32'd0);
        rst_n = 1'b1;
        tick();
        expect_cell("reset seed (1,0)", 1, 0, 1'b0, 1'b1);
        expect_cell("reset seed (0,0)", 0, 0, 1'b0, 1'b0);

        // Blinker
        clear_board();
        do_write(3, 2, 1'b1);
        do_write(3, 3, 1'b1);
        do_write(3, 4, 1'b1);
        do_step(1'b0);
        wait_done();
        check("blinker pop", {25'b0, pop_count}, 32'd3);
        check("blinker gen", {16'b0, gen_count}, 32'd1);
        expect_cell("blinker (2,3)", 2, 3, 1'b0, 1'b1);
        expect_cell("blinker (3,3)", 3, 3, 1'b0, 1'b1);
        expect_cell("blinker (4,3)", 4, 3, 1'b0, 1'b1);
        expect_cell("blinker (3,2)", 3, 2, 1'b0, 1'b0);

        // Second step with timing and busy-drop checks
        do_step(1'b0);
        cyc = 1;
        busy_cycles = 0;
        while (gen_done !== 1'b1 && cyc < 200) begin
            if (busy === 1'b1) busy_cycles++;
            if (cyc == 10) begin
                frame_tick = 1'b1; run = 1'b1;
                cell_wr_x = 3'd0; cell_wr_y = 3'd0; cell_wr_val = 1'b1; cell_wr = 1'b1;
            end
            if (cyc == 11) begin
                frame_tick = 1'b0; run = 1'b0; cell_wr = 1'b0;
            end
            if (cyc == 30) begin
                man_addr = 6'(3*BW + 2);
                use_man  = 1'b1;
                #1;
                v = rd_cell;
                use_man = 1'b0;
                check("old gen shown while busy (2,3)", {31'b0, v}, 32'd1);
            end
            tick();
            cyc++;
        end
        check("gen_done latency", cyc, 32'd66);
        check("busy cycles", busy_cycles, 32'd65);
        check("busy low at done", {31'b0, busy}, 32'd0);
        tick();
        check("blinker gen 2", {16'b0, gen_count}, 32'd2);
        expect_cell("blinker back (3,2)", 3, 2, 1'b0, 1'b1);
        expect_cell("blinker back (2,3)", 2, 3, 1'b0, 1'b0);
        expect_cell("busy cell_wr dropped", 0, 0, 1'b0, 1'b0);
        repeat (5) tick();
        check("busy frame_tick dropped", {16'b0, gen_count}, 32'd2);

        // Bottom-edge row, no wrap then wrap
        clear_board();
        do_write(0, 7, 1'b1); do_write(1, 7, 1'b1); do_write(2, 7, 1'b1);
        do_step(1'b0);
        wait_done();
        check("edge nowrap pop", {25'b0, pop_count}, 32'd2);
        expect_cell("edge nowrap (1,6)", 1, 6, 1'b0, 1'b1);
        expect_cell("edge nowrap (1,0)", 1, 0, 1'b0, 1'b0);
        clear_board();
        do_write(0, 7, 1'b1); do_write(1, 7, 1'b1); do_write(2, 7, 1'b1);
        do_step(1'b1);
        wait_done();
        check("edge wrap pop", {25'b0, pop_count}, 32'd3);
        expect_cell("edge wrap (1,0)", 1, 0, 1'b0, 1'b1);

        // Custom B1/S rule on the second instance
        clear_board();
        do_write(4, 4, 1'b1);
        do_step(1'b0);
        wait_done();
        check("B1 pop", {25'b0, pop_count2}, 32'd8);
        check("B3S23 lone cell dies", {25'b0, pop_count}, 32'd0);
        expect_cell("B1 centre", 4, 4, 1'b1, 1'b0);
        expect_cell("B1 (3,3)", 3, 3, 1'b1, 1'b1);
        expect_cell("B1 (5,5)", 5, 5, 1'b1, 1'b1);
        expect_cell("B1 (4,6)", 4, 6, 1'b1, 1'b0);

        // seed_load beats a simultaneous step
        seed_load = 1'b1;
        step      = 1'b1;
        tick();
        seed_load = 1'b0;
        step      = 1'b0;
        check("seed+step not busy", {31'b0, busy}, 32'd0);
        tick();
        check("seed+step gen unchanged", {16'b0, gen_count}, 32'd5);
        expect_cell("seed loaded (2,1)", 2, 1, 1'b0, 1'b1);

        // Glider on the torus, free-running
        wrap = 1'b1;
        run  = 1'b1;
        for (int g = 0; g < 32; g++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            repeat (199) tick();
        end
        run = 1'b0;
        tick();
        check("glider gen", {16'b0, gen_count}, 32'd37);
        check("glider pop", {25'b0, pop_count}, 32'd5);
        count_seed_mismatch(mism);
        check("glider returns home", mism, 32'd0);

        // Asynchronous reset during EVAL idx 20
        do_step(1'b0);
        n = 0;
        while (m_phase != 22 && n < 100) begin
            tick();
            n++;
        end
        check("reached eval idx 20", m_phase, 32'd22);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort gen_done", {31'b0, gen_done}, 32'd0);
        check("abort gen_count", {16'b0, gen_count}, 32'd0);
        check("abort pop_count", {25'b0, pop_count}, 32'd0);
        tick();
        count_seed_mismatch(mism);
        check("abort board is seed", mism, 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle after reset", {31'b0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
